// File: rtl/hid_type_sequencer.sv
// ASCII character stream to USB HID keyboard press/release report pairs,
// with fixed key-hold and inter-key gap timing.
module hid_type_sequencer #(
  parameter int HOLD_CYCLES = 500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [6:0]  char_data,
  output logic        char_ready,
  output logic [6:0]  lut_key,
  input  logic [7:0]  lut_value,
  output logic        report_valid,
  output logic [15:0] report_data,
  input  logic        report_ready,
  output logic        busy,
  output logic        drop_pulse
);

  typedef enum logic [2:0] {IDLE, LOOKUP, PRESS, HOLD, RELEASE, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [6:0]       char_reg, char_next;
  logic [6:0]       key_reg, key_next;
  logic             shift_reg, shift_next;
  logic             drop_reg, drop_next;
  logic [127:0]     supported_map;
  logic             supported;

  // Codes outside this set never reach the LUT (code 0 maps to a null key).
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_map
      assign supported_map[gi] = (gi >= 32) || (gi == 8) ||
                                 (gi >= 17 && gi <= 20) || (gi == 27);
    end
  endgenerate

  assign supported  = supported_map[char_data];
  assign lut_key    = char_reg;
  assign busy       = (state_reg != IDLE);
  assign drop_pulse = drop_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    char_next    = char_reg;
    key_next     = key_reg;
    shift_next   = shift_reg;
    drop_next    = 1'b0;
    char_ready   = 1'b0;
    report_valid = 1'b0;
    report_data  = 16'h0000;
    case (state_reg)
      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          if (supported) begin
            char_next  = char_data;
            state_next = LOOKUP;
          end else begin
            drop_next = 1'b1;
          end
        end
      end
      LOOKUP: begin
        key_next   = lut_value[6:0];
        shift_next = lut_value[7];
        state_next = PRESS;
      end
      PRESS: begin
        report_valid = 1'b1;
        report_data  = {(shift_reg ? 8'h02 : 8'h00), 1'b0, key_reg};
        if (report_ready) begin
          cnt_next   = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == HOLD_LAST) state_next = RELEASE;
      end
      RELEASE: begin
        report_valid = 1'b1;
        if (report_ready) begin
          cnt_next   = '0;
          state_next = GAP;
        end
      end
      GAP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      char_reg  <= '0;
      key_reg   <= '0;
      shift_reg <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      char_reg  <= char_next;
      key_reg   <= key_next;
      shift_reg <= shift_next;
      drop_reg  <= drop_next;
    end
  end

endmodule

// File: doc/hid_type_sequencer.md
Name: hid_type_sequencer

Overview:
- Converts a stream of 7-bit ASCII characters into timed USB HID keyboard press/release report pairs.
- Drives the combinational ASCII-to-HID lookup table through the lut_key/lut_value pair. lut_value bit7 is the shift flag; bits[6:0] are the HID usage ID.
- Sits between the text source (FIFO/UART) and the USB interrupt-IN endpoint packer, and enforces key hold and inter-key gap times.

Parameters:
- HOLD_CYCLES, 500000, number of cycles spent in HOLD between the press report and the release report; must be at least 1.
- GAP_CYCLES, 500000, number of cycles spent in GAP after the release report; must be at least 1.
- CNT_W, 20, counter width; must satisfy 2**CNT_W > max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  input character valid.
- char_data  in  7  ASCII character.
- char_ready  out  1  accepts a character; high only in IDLE.
- lut_key  out  7  lookup table address.
- lut_value  in  8  lookup table data, combinational from lut_key.
- report_valid  out  1  HID report valid.
- report_data  out  16  [15:8] modifier byte, [7:0] keycode.
- report_ready  in  1  endpoint accepts the report.
- busy  out  1  high whenever state != IDLE.
- drop_pulse  out  1  one-cycle pulse when a character is rejected.

Behaviour:
- States: IDLE, LOOKUP, PRESS, HOLD, RELEASE, GAP.
- Reset: state=IDLE, counter=0, char_q=0, key_q=0, shift_q=0. Outputs: report_valid=0, report_data=16'h0000, drop_pulse=0, busy=0, char_ready=1 on the first cycle after reset.
- Supported set: 8, 17, 18, 19, 20, 27, and 32..127 decimal. All other codes are never presented to the LUT; this includes 0, whose LUT entry is a null key.
- IDLE: char_ready=1. On char_valid & char_ready:
  - Supported code: latch char_data into char_q and go to LOOKUP.
  - Unsupported code: assert drop_pulse on the next cycle and stay in IDLE.
- lut_key = char_q, combinational and registered-source; it holds its value outside LOOKUP.
- LOOKUP (1 cycle): key_q <= lut_value[6:0], shift_q <= lut_value[7]; go to PRESS. lut_value is only sampled in LOOKUP.
- PRESS: report_valid=1, report_data = {(shift_q ? 8'h02 : 8'h00), 1'b0, key_q}. Modifier 8'h02 is Left Shift.
  - report_data stays stable while report_valid=1 and report_ready=0.
  - On report_ready: counter <= 0, go to HOLD.
- HOLD: counter increments each cycle. When counter == HOLD_CYCLES-1, go to RELEASE. The block spends exactly HOLD_CYCLES cycles in HOLD.
- RELEASE: report_valid=1, report_data=16'h0000. On report_ready: counter <= 0, go to GAP.
- GAP: exactly GAP_CYCLES cycles, then IDLE.
- report_valid is 0 in IDLE, LOOKUP, HOLD and GAP; report_data=16'h0000 in those states.
- Latency: character accepted at edge t gives first report_valid=1 at t+2.
  - With report_ready tied high, consecutive accepts are spaced 4+HOLD_CYCLES+GAP_CYCLES cycles apart.
- Repeated identical characters always produce a full release and gap, so the host sees distinct keystrokes.
- report_valid must not drop, and report_data must not change, until the handshake completes (AXI-stream style).
- rst asserted mid-operation: next cycle state=IDLE and report_valid=0.
  - No release report is emitted; the endpoint packer is responsible for clearing stale reports on reset.
- Simultaneous char_valid while not in IDLE: ignored (char_ready=0); the source must hold the character.
- No combinational path from report_ready to report_valid/report_data, or from char_valid to char_ready.

Test Plan:
- HOLD=4, GAP=3, report_ready=1; send 'a' (0x61): LUT returns 8'h04. Required: PRESS report 16'h0004 at t+2, RELEASE report 16'h0000 exactly 5 cycles later, char_ready high again 4 cycles after RELEASE.
- Send 'A' (0x41) with LUT returning 8'h84: required report 16'h0204 then 16'h0000. Send DEL (0x7F) with LUT returning 8'h4C: required report 16'h004C.
- Send 0x01, then 0x00, then 0x15: each gives one drop_pulse, no report_valid, and char_ready stays 1. Then send 'b' (0x62): required report 16'h0005.
- Backpressure: hold report_ready=0 for 5 cycles in PRESS and then in RELEASE. Required: report_valid and report_data stable for all 5 cycles, and the HOLD count starts only after the handshake.
- Stream "aa" back-to-back with char_valid held high: required two full 16'h0004/16'h0000 pairs, with accepts exactly 11 cycles apart (HOLD=4, GAP=3).
- Assert rst for 1 cycle during HOLD: required next cycle state=IDLE, report_valid=0, busy=0, char_ready=1. A following 'c' (0x63) gives report 16'h0006 normally.
